// File: rtl/dmem_resp_port.sv
// Data-side memory responder: tagged read/write/cache-op requests against a word SRAM,
// fixed-latency in-order responses. Define DMEM_STALL_INJECT_EN for LFSR-driven accept stalls.
module dmem_resp_port #(
  parameter logic [31:0] ADDR_BASE       = 32'h8000_0000,
  parameter int unsigned MEM_WORDS       = 32768,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_d_addr_i,
  input  logic [31:0] mem_d_data_wr_i,
  input  logic        mem_d_rd_i,
  input  logic [3:0]  mem_d_wr_i,
  input  logic        mem_d_cacheable_i,
  input  logic [10:0] mem_d_req_tag_i,
  input  logic        mem_d_invalidate_i,
  input  logic        mem_d_writeback_i,
  input  logic        mem_d_flush_i,
  output logic        mem_d_accept_o,
  output logic        mem_d_ack_o,
  output logic [31:0] mem_d_data_rd_o,
  output logic        mem_d_error_o,
  output logic [10:0] mem_d_resp_tag_o
);

  localparam int unsigned IdxW   = $clog2(MEM_WORDS);
  localparam logic [32:0] AddrLo = {1'b0, ADDR_BASE};
  localparam logic [32:0] AddrHi = AddrLo + 33'(MEM_WORDS) * 33'd4;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [10:0] tag;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem_q [MEM_WORDS];
  resp_t       pipe_q [LATENCY];
  resp_t       pipe_d [LATENCY];
  resp_t       new_resp;
  logic [3:0]  outstanding_q, outstanding_d;

  logic            req, hs, is_wr, is_rd, hit, stall, ack;
  logic [31:0]     addr_off;
  logic [IdxW-1:0] idx;
  logic            unused_bits;

  assign addr_off    = mem_d_addr_i - ADDR_BASE;
  assign idx         = addr_off[IdxW+1:2];
  assign hit         = ({1'b0, mem_d_addr_i} >= AddrLo) && ({1'b0, mem_d_addr_i} < AddrHi);
  assign unused_bits = ^{mem_d_cacheable_i, addr_off[1:0], addr_off[31:IdxW+2]};

  assign is_wr = |mem_d_wr_i;
  assign is_rd = mem_d_rd_i & ~is_wr;
  assign req   = is_wr | mem_d_rd_i | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;

`ifdef DMEM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Accept depends only on registered state so it never loops back through the requester.
  assign mem_d_accept_o = ~rst_i & ~stall & (32'(outstanding_q) < MAX_OUTSTANDING);
  assign hs             = req & mem_d_accept_o;
  assign ack            = pipe_q[LATENCY-1].valid;

  always_comb begin
    new_resp       = '0;
    new_resp.valid = hs;
    new_resp.error = hs & (is_wr | is_rd) & ~hit;
    new_resp.tag   = hs ? mem_d_req_tag_i : 11'd0;
    new_resp.data  = (hs & is_rd & hit) ? mem_q[idx] : 32'd0;
    pipe_d[0]      = new_resp;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({hs, ack})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= 4'd0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // SRAM is deliberately left out of reset so contents survive a core reset.
  always_ff @(posedge clk_i) begin
    if (hs && is_wr && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_d_wr_i[b]) mem_q[idx][8*b +: 8] <= mem_d_data_wr_i[8*b +: 8];
      end
    end
  end

  assign mem_d_ack_o      = ack;
  assign mem_d_error_o    = pipe_q[LATENCY-1].error;
  assign mem_d_resp_tag_o = pipe_q[LATENCY-1].tag;
  assign mem_d_data_rd_o  = pipe_q[LATENCY-1].data;

  task write(input logic [31:0] byte_idx, input logic [7:0] val);
    mem_q[byte_idx[IdxW+1:2]][{byte_idx[1:0], 3'b000} +: 8] <= val;
  endtask

endmodule

// File: tb/tb_dmem_resp_port.sv
// Bench for dmem_resp_port: directed scenarios plus random traffic checked against a
// byte-array memory and an expected-response queue keyed by due cycle.
module tb_dmem_resp_port;

  localparam logic [31:0] Base   = 32'h8000_0000;
  localparam int unsigned Words  = 32768;
  localparam int unsigned Lat    = 8;
  localparam int unsigned MaxOut = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] mem_d_addr_i = '0, mem_d_data_wr_i = '0;
  logic        mem_d_rd_i = 1'b0, mem_d_cacheable_i = 1'b0;
  logic [3:0]  mem_d_wr_i = '0;
  logic [10:0] mem_d_req_tag_i = '0;
  logic        mem_d_invalidate_i = 1'b0, mem_d_writeback_i = 1'b0, mem_d_flush_i = 1'b0;
  logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [31:0] mem_d_data_rd_o;
  logic [10:0] mem_d_resp_tag_o;

  dmem_resp_port #(
    .ADDR_BASE(Base), .MEM_WORDS(Words), .LATENCY(Lat), .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
    .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
    .mem_d_flush_i(mem_d_flush_i), .mem_d_accept_o(mem_d_accept_o),
    .mem_d_ack_o(mem_d_ack_o), .mem_d_data_rd_o(mem_d_data_rd_o),
    .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [10:0] tag;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem_m [int unsigned];
  int unsigned n_pass = 0, n_fail = 0, n_total = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %h required %h", name, cyc, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    longint la, lb;
    la = {32'd0, a};
    lb = {32'd0, Base};
    return (la >= lb) && (la < lb + 4 * longint'(Words));
  endfunction

  function automatic int unsigned word_off(input logic [31:0] a);
    return (a - Base) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int unsigned o;
    o = word_off(a);
    return {mem_m[o+3], mem_m[o+2], mem_m[o+1], mem_m[o]};
  endfunction

  // One clock of stimulus: predict accept, update the model on handshake, check the response.
  task automatic step(input logic rst, input logic rd, input logic [3:0] wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [10:0] tag, input logic [2:0] cmo);
    logic exp_acc;
    exp_t e;
    int unsigned o;
    @(negedge clk);
    rst_i = rst; mem_d_rd_i = rd; mem_d_wr_i = wr; mem_d_addr_i = addr;
    mem_d_data_wr_i = data; mem_d_req_tag_i = tag; mem_d_cacheable_i = $urandom_range(0, 1);
    {mem_d_flush_i, mem_d_writeback_i, mem_d_invalidate_i} = cmo;
    #1;
    exp_acc = !rst && (q.size() < MaxOut);
    check("accept", 32'(mem_d_accept_o), 32'(exp_acc));
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if ((rd || wr != 4'd0 || cmo != 3'd0) && exp_acc) begin
        e.due = cyc + Lat; e.tag = tag; e.err = 1'b0; e.data = '0;
        if (wr != 4'd0) begin
          if (in_range(addr)) begin
            o = word_off(addr);
            for (int b = 0; b < 4; b++) if (wr[b]) mem_m[o+b] = data[8*b +: 8];
          end else e.err = 1'b1;
        end else if (rd) begin
          if (in_range(addr)) e.data = rd_word(addr);
          else e.err = 1'b1;
        end
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      check("ack", 32'(mem_d_ack_o), 32'd1);
      check("resp_tag", 32'(mem_d_resp_tag_o), 32'(q[0].tag));
      check("data_rd", mem_d_data_rd_o, q[0].data);
      check("error", 32'(mem_d_error_o), 32'(q[0].err));
    end else begin
      check("no_ack", 32'(mem_d_ack_o), 32'd0);
      check("idle_tag", 32'(mem_d_resp_tag_o), 32'd0);
      check("idle_data", mem_d_data_rd_o, 32'd0);
      check("idle_error", 32'(mem_d_error_o), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 11'd0, 3'd0);
  endtask

  function automatic logic [31:0] pool_addr(input int i);
    return (i == 6) ? 32'h8001_FFFC : Base + 32'(4 * i);
  endfunction

  initial begin
    logic [31:0] bd;
    logic [31:0] a;
    int r;
    // Backdoor preload survives reset
    bd = 32'h1122_3344;
    for (int b = 0; b < 4; b++) begin
      dut.write(32'h40 + 32'(b), bd[8*b +: 8]);
      mem_m[32'h40 + b] = bd[8*b +: 8];
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 11'd0, 3'd0);
    step(1'b0, 1'b1, 4'd0, Base + 32'h40, 32'd0, 11'd1, 3'd0);
    idle(Lat + 1);

    // Full write then read-back; then a single-byte overwrite
    step(1'b0, 1'b0, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 11'd5, 3'd0);
    step(1'b0, 1'b1, 4'd0, 32'h8000_0010, 32'd0, 11'd6, 3'd0);
    idle(Lat);
    step(1'b0, 1'b0, 4'h1, 32'h8000_0010, 32'h0000_00AA, 11'd7, 3'd0);
    step(1'b0, 1'b1, 4'd0, 32'h8000_0012, 32'd0, 11'd8, 3'd0);
    idle(Lat);

    // Range boundaries: just below base, one past the end, and a write miss
    step(1'b0, 1'b1, 4'd0, 32'h7FFF_FFFC, 32'd0, 11'd9, 3'd0);
    step(1'b0, 1'b1, 4'd0, 32'h8002_0000, 32'd0, 11'd10, 3'd0);
    step(1'b0, 1'b0, 4'hF, 32'h8002_0000, 32'h1234_5678, 11'd11, 3'd0);
    step(1'b0, 1'b0, 4'd0, 32'h8002_0000, 32'd0, 11'd12, 3'b101);
    idle(Lat);

    // Pool init, including the last word in range
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'hF, pool_addr(i), $urandom, 11'(20 + i), 3'd0);
    step(1'b0, 1'b1, 4'd0, 32'h8001_FFFC, 32'd0, 11'd30, 3'd0);
    step(1'b0, 1'b1, 4'd0, 32'h8000_0010, 32'd0, 11'd31, 3'd0);
    idle(Lat);

    // Saturate the outstanding limit with continuous reads
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 4'd0, pool_addr(i % 7), 32'd0, 11'(256 + i), 3'd0);
    idle(Lat + 2);

    // Reset with requests in flight drops their responses
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, pool_addr(i), 32'd0, 11'(400 + i), 3'd0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 11'd0, 3'd0);
    idle(Lat + 3);
    step(1'b0, 1'b1, 4'd0, pool_addr(1), 32'd0, 11'd410, 3'd0);
    idle(Lat);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = pool_addr($urandom_range(0, 6)) | 32'($urandom_range(0, 3));
      if (r <= 2) step(1'b0, 1'b1, 4'd0, a, 32'd0, 11'($urandom), 3'd0);
      else if (r <= 5)
        step(1'b0, $urandom_range(0, 1), 4'($urandom_range(1, 15)), a, $urandom, 11'($urandom), 3'd0);
      else if (r == 6) begin
        a = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFC : 32'h8002_0000 + 32'($urandom_range(0, 64));
        step(1'b0, 1'b1, 4'($urandom_range(0, 1) * 15), a, $urandom, 11'($urandom), 3'd0);
      end else if (r == 7)
        step(1'b0, 1'b0, 4'd0, $urandom, 32'd0, 11'($urandom), 3'($urandom_range(1, 7)));
      else idle(1);
    end
    idle(Lat + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
